mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one N:1 single-bit mux among N requesters.
- It owns the mux select: grants one requester at a time, holds the grant until release or timeout, then rotates priority.
- It drives `sel` into an internal mux instance and presents the routed bit with a valid flag.
- It sits between requester logic and the shared output line.

Parameters:
- sel_width, 3: select width; N = 2**sel_width requesters/data inputs.
- hold_max, 16: max consecutive cycles one owner may hold the grant; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; held high while access is wanted.
- in  input  N  data bits; bit i belongs to requester i.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- sel  output  sel_width  index of current owner (registered); drives the mux.
- valid  output  1  high while a grant is active.
- out  output  1  in[sel] when valid, else 0 (combinational from in).
- timeout  output  1  one-cycle pulse when a grant is revoked by hold_max expiry.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - gnt=0, sel=0, valid=0, timeout=0.
  - state=IDLE, priority pointer ptr=0, hold counter hcnt=0.
  - `out` therefore reads 0.
  - Reset overrides everything, including mid-grant; no grant survives reset.
- States:
  - IDLE: no owner.
  - BUSY: owner = sel, valid=1, gnt = 1<<sel.
- Arbitration function: first index i scanning ptr, ptr+1, ..., wrapping mod N, with req[i]=1.
- IDLE -> BUSY:
  - Trigger: any req bit high at the edge.
  - Grant goes to the arbitration winner; hcnt=0.
  - Latency: req seen at edge k -> gnt/valid high after edge k (one cycle).
- BUSY, release condition at an edge: req[sel]==0 OR hcnt==hold_max-1.
  - On release:
    - ptr = (sel+1) mod N, wrapping from N-1 to 0.
    - Arbitrate immediately with the new ptr; the previous owner competes only at lowest priority.
    - Winner exists -> stay BUSY, regrant in the same edge (no idle bubble), hcnt=0.
    - No winner -> IDLE, gnt=0, valid=0.
  - No release: hcnt increments; gnt/sel hold.
- timeout:
  - High for exactly the cycle after an edge where the release was caused by hcnt==hold_max-1 while req[sel] was still 1.
  - If the timed-out owner is the only requester, it is regranted with hcnt=0 and timeout still pulses.
- hold_max=1: every owner releases after one cycle; grants rotate every cycle among active requesters.
- hcnt width: clog2(hold_max), minimum 1; never exceeds hold_max-1.
- Requests arriving mid-grant do not preempt; they wait for release.
- gnt is always one-hot or zero; sel is stable whenever valid=0 (holds last owner, or 0 after reset).

Decomposition:
- Shared package:
  - state encoding (IDLE=0, BUSY=1).
  - function computing the rotating-priority winner index plus found flag from (req, ptr).
  - clog2 helper for the hcnt width.
- One sub-module: the existing parameterized `mux` (sel_width), instantiated once with in/sel, output gated by valid.

Test Plan:
- Hold rst=1 with req=8'hFF for 3 cycles -> gnt=0, valid=0, out=0 throughout. Release rst -> gnt=8'h01, sel=0 one cycle later.
- req=8'h20 for 3 cycles, then 0, with in toggling -> gnt=8'h20, sel=5 for 3 cycles and out==in[5]. The cycle after req drops: gnt=0, valid=0, out=0, ptr=6.
- hold_max=4, req=8'hFF steady -> owners 0,1,2,...,7,0 each for exactly 4 cycles, no idle gaps, timeout pulses once per handoff.
- Owner 0 drops req while req[3] and req[6] are high -> next cycle gnt=8'h08, no valid gap, timeout=0.
- Owner 7 releases with req[0] and req[6] high -> gnt=8'h01 (wrap), sel=0.
- rst asserted mid-grant at hcnt=2 -> next cycle gnt=0, valid=0, ptr=0. After rst deasserts with req=8'h81 -> gnt=8'h01.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

   localparam int unsigned MAX_SEL_WIDTH = 8;
   localparam int unsigned MAX_N         = 2 ** MAX_SEL_WIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic                     found;
      logic [MAX_SEL_WIDTH-1:0] idx;
   } pick_t;

   // Width needed to count 0..v-1, never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned w;
      w = 1;
      while ((w < 31) && ((32'd1 << w) < v)) w++;
      return w;
   endfunction

   // First requester found scanning ptr, ptr+1, ... modulo n.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0]         req,
                                     input logic [MAX_SEL_WIDTH-1:0] ptr,
                                     input int unsigned              n);
      pick_t                    p;
      logic [MAX_SEL_WIDTH-1:0] idx;
      p = '0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         if (k < n) begin
            idx = MAX_SEL_WIDTH'((32'(ptr) + k) % n);
            if (!p.found && req[idx]) begin
               p.found = 1'b1;
               p.idx   = idx;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Parameterized N:1 single-bit mux.
module mux #(
   parameter int unsigned sel_width = 3
) (
   input  logic [(2**sel_width)-1:0] in,
   input  logic [sel_width-1:0]      sel,
   output logic                      out
);

   assign out = in[sel];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared N:1 bit mux.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned sel_width = 3,
   parameter int unsigned hold_max  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [(2**sel_width)-1:0] req,
   input  logic [(2**sel_width)-1:0] in,
   output logic [(2**sel_width)-1:0] gnt,
   output logic [sel_width-1:0]      sel,
   output logic                      valid,
   output logic                      out,
   output logic                      timeout
);

   localparam int unsigned n      = 2 ** sel_width;
   localparam int unsigned hcnt_w = clog2(hold_max);

   state_t               state_q, state_d;
   logic [sel_width-1:0] ptr_q, ptr_d;
   logic [hcnt_w-1:0]    hcnt_q, hcnt_d;
   logic [sel_width-1:0] sel_d;
   logic [n-1:0]         gnt_d;
   logic                 valid_d;
   logic                 timeout_d;
   logic [sel_width-1:0] next_ptr;
   logic                 expired;
   logic                 release_now;
   pick_t                pick_idle;
   pick_t                pick_rot;
   logic                 mux_bit;

   // State and output registers; synchronous reset clears any grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hcnt_q  <= '0;
         sel     <= '0;
         gnt     <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hcnt_q  <= hcnt_d;
         sel     <= sel_d;
         gnt     <= gnt_d;
         valid   <= valid_d;
         timeout <= timeout_d;
      end
   end

   // Next-state: grant from idle, or release/rotate/regrant while busy.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hcnt_d      = hcnt_q;
      sel_d       = sel;
      timeout_d   = 1'b0;
      next_ptr    = sel + sel_width'(1);
      expired     = (hcnt_q == hcnt_w'(hold_max - 1));
      release_now = !req[sel] || expired;
      pick_idle   = rr_pick(MAX_N'(req), MAX_SEL_WIDTH'(ptr_q), n);
      pick_rot    = rr_pick(MAX_N'(req), MAX_SEL_WIDTH'(next_ptr), n);

      case (state_q)
         IDLE: begin
            if (pick_idle.found) begin
               state_d = BUSY;
               sel_d   = sel_width'(pick_idle.idx);
               hcnt_d  = '0;
            end
         end
         BUSY: begin
            if (release_now) begin
               ptr_d     = next_ptr;
               timeout_d = req[sel] && expired;
               hcnt_d    = '0;
               if (pick_rot.found) begin
                  sel_d = sel_width'(pick_rot.idx);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hcnt_d = hcnt_q + hcnt_w'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = (state_d == BUSY);
      gnt_d   = valid_d ? (n'(1) << sel_d) : '0;
   end

   mux #(.sel_width(sel_width)) u_mux (
      .in  (in),
      .sel (sel),
      .out (mux_bit)
   );

   assign out = valid & mux_bit;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized bench comparing two arbiter configurations against an owner-based model.
module tb_mux_rr_arbiter;

   localparam int N = 8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] in;

   logic [7:0] gnt_o   [2];
   logic [2:0] sel_o   [2];
   logic       valid_o [2];
   logic       out_o   [2];
   logic       to_o    [2];

   int n_checks = 0;
   int n_pass   = 0;

   // Model: owner index (-1 when idle), rotation pointer, cycles held.
   int m_own [2];
   int m_ptr [2];
   int m_hc  [2];
   int m_sel [2];
   bit m_to  [2];
   int hmax  [2];

   mux_rr_arbiter #(.sel_width(3), .hold_max(16)) dut16 (
      .clk(clk), .rst(rst), .req(req), .in(in),
      .gnt(gnt_o[0]), .sel(sel_o[0]), .valid(valid_o[0]),
      .out(out_o[0]), .timeout(to_o[0])
   );

   mux_rr_arbiter #(.sel_width(3), .hold_max(4)) dut4 (
      .clk(clk), .rst(rst), .req(req), .in(in),
      .gnt(gnt_o[1]), .sel(sel_o[1]), .valid(valid_o[1]),
      .out(out_o[1]), .timeout(to_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   function automatic int find(input logic [7:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[3'((p + k) % N)]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_step(input int d, input bit r, input logic [7:0] rq);
      int w;
      m_to[d] = 1'b0;
      if (r) begin
         m_own[d] = -1; m_ptr[d] = 0; m_hc[d] = 0; m_sel[d] = 0;
      end else if (m_own[d] < 0) begin
         w = find(rq, m_ptr[d]);
         if (w >= 0) begin m_own[d] = w; m_sel[d] = w; m_hc[d] = 0; end
      end else if (!rq[3'(m_own[d])] || m_hc[d] == hmax[d] - 1) begin
         m_to[d]  = rq[3'(m_own[d])];
         m_ptr[d] = (m_own[d] + 1) % N;
         m_hc[d]  = 0;
         w = find(rq, m_ptr[d]);
         if (w >= 0) begin m_own[d] = w; m_sel[d] = w; end
         else m_own[d] = -1;
      end else begin
         m_hc[d]++;
      end
   endtask

   task automatic compare(input int d);
      logic [7:0] eg;
      logic       ev, eo;
      eg = '0;
      ev = (m_own[d] >= 0);
      if (ev) eg[3'(m_own[d])] = 1'b1;
      eo = ev ? in[3'(m_own[d])] : 1'b0;
      check($sformatf("gnt[h%0d]", hmax[d]),     32'(gnt_o[d]),   32'(eg));
      check($sformatf("sel[h%0d]", hmax[d]),     32'(sel_o[d]),   32'(m_sel[d]));
      check($sformatf("valid[h%0d]", hmax[d]),   32'(valid_o[d]), 32'(ev));
      check($sformatf("out[h%0d]", hmax[d]),     32'(out_o[d]),   32'(eo));
      check($sformatf("timeout[h%0d]", hmax[d]), 32'(to_o[d]),    32'(m_to[d]));
   endtask

   // One clock: drive on falling edge, advance model at rising edge, check just after.
   task automatic cycle(input bit r, input logic [7:0] rq, input logic [7:0] dv);
      @(negedge clk);
      rst = r; req = rq; in = dv;
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_step(d, r, rq);
      #1;
      for (int d = 0; d < 2; d++) compare(d);
   endtask

   initial begin
      hmax[0] = 16; hmax[1] = 4;
      for (int d = 0; d < 2; d++) begin
         m_own[d] = -1; m_ptr[d] = 0; m_hc[d] = 0; m_sel[d] = 0; m_to[d] = 1'b0;
      end
      rst = 1'b1; req = '0; in = '0;

      // Reset held with all requests high, then first grant.
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 8'($urandom));
      cycle(1'b0, 8'hFF, 8'($urandom));

      // Single requester 5 with toggling data, then drop.
      cycle(1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h20, 8'($urandom));
      cycle(1'b0, 8'h00, 8'hFF);

      // All requesting: full rotation with timeouts.
      cycle(1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 40; i++) cycle(1'b0, 8'hFF, 8'($urandom));

      // Owner 0 drops while 3 and 6 wait.
      cycle(1'b1, 8'h00, 8'h00);
      cycle(1'b0, 8'h01, 8'h00);
      cycle(1'b0, 8'h49, 8'($urandom));
      cycle(1'b0, 8'h48, 8'($urandom));
      cycle(1'b0, 8'h48, 8'($urandom));

      // Owner 7 releases, pointer wraps to 0.
      cycle(1'b1, 8'h00, 8'h00);
      cycle(1'b0, 8'h80, 8'h80);
      cycle(1'b0, 8'hC1, 8'($urandom));
      cycle(1'b0, 8'h41, 8'($urandom));

      // Reset mid-grant, then requests 0 and 7.
      cycle(1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h01, 8'($urandom));
      cycle(1'b1, 8'h01, 8'h01);
      cycle(1'b0, 8'h81, 8'h01);
      cycle(1'b0, 8'h81, 8'h01);

      // Random traffic with sparse/dense request mixes and rare resets.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] rq;
         case ($urandom_range(0, 3))
            0:       rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
            1:       rq = 8'($urandom);
            2:       rq = 8'($urandom) | 8'($urandom);
            default: rq = req;
         endcase
         cycle($urandom_range(0, 63) == 0, rq, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
